alsu_driver: RTL and testbench

ALSU_DRIVER -- requirements
Module: alsu_driver

---
 rtl/alsu_driver.sv | 202 ++++++++++++++++++++
 tb/tb_alsu_driver.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_driver.sv
// rtl/alsu_driver.sv - command/response front end for a two-stage registered ALSU
//
// Purpose:
//   Accepts commands through a valid/ready handshake and loads each one into
//   registered ALSU pins. An idle cycle drives a NOP (bypass_A with A=0). A
//   three-stage valid/invalid tracker follows each command through the ALSU's
//   input and output registers. The ALSU result is then captured into a
//   response FIFO, which is drained through a second valid/ready handshake.
//   Credits (FIFO fill plus commands in flight) gate req_ready, so the FIFO
//   cannot overflow.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   req_valid / req_ready      command handshake (req_ready is combinational)
//   req_opcode, req_a, req_b   command opcode and signed operands
//   req_cin .. req_bypass_b    command control bits
//   alsu_opcode .. alsu_bypass_B  registered ALSU pins
//   alsu_out, alsu_leds        ALSU result and LED outputs
//   rsp_valid / rsp_ready      response handshake
//   rsp_out, rsp_invalid       FIFO head: captured result, invalid-command flag
//   proto_err                  sticky protocol/consistency error

module alsu_driver #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_opcode,
    input  logic [2:0]  req_a,
    input  logic [2:0]  req_b,
    input  logic        req_cin,
    input  logic        req_serial_in,
    input  logic        req_direction,
    input  logic        req_red_op_a,
    input  logic        req_red_op_b,
    input  logic        req_bypass_a,
    input  logic        req_bypass_b,
    output logic [2:0]  alsu_opcode,
    output logic [2:0]  alsu_a,
    output logic [2:0]  alsu_b,
    output logic        alsu_cin,
    output logic        alsu_serial_in,
    output logic        alsu_direction,
    output logic        alsu_red_op_A,
    output logic        alsu_red_op_B,
    output logic        alsu_bypass_A,
    output logic        alsu_bypass_B,
    input  logic [5:0]  alsu_out,
    input  logic [15:0] alsu_leds,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [5:0]  rsp_out,
    output logic        rsp_invalid,
    output logic        proto_err
);

    // Count must hold DEPTH (up to 16) plus three in-flight commands.
    localparam int CW = 5;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pin vector layout:
    // {opcode, a, b, cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B}
    localparam logic [15:0] PINS_NOP = 16'h0002;

    logic [15:0]   req_pins;
    logic [15:0]   pins_d, pins_q;
    logic          req_fire;
    logic          req_inv;

    logic          v0_d, v0_q;
    logic          v1_d, v1_q;
    logic          v2_d, v2_q;
    logic          inv0_d, inv0_q;
    logic          inv1_d, inv1_q;
    logic          inv2_d, inv2_q;

    logic [CW-1:0] count_d, count_q;
    logic [PW-1:0] wr_ptr_d, wr_ptr_q;
    logic [PW-1:0] rd_ptr_d, rd_ptr_q;
    logic          err_d, err_q;

    logic [CW-1:0] occupancy;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic [6:0]    rd_data;
    logic [6:0]    mem_q [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign req_pins = {req_opcode, req_a, req_b, req_cin, req_serial_in,
                       req_direction, req_red_op_a, req_red_op_b,
                       req_bypass_a, req_bypass_b};

    assign {alsu_opcode, alsu_a, alsu_b, alsu_cin, alsu_serial_in,
            alsu_direction, alsu_red_op_A, alsu_red_op_B,
            alsu_bypass_A, alsu_bypass_B} = pins_q;

    // Reduction on a non-logic opcode, or opcodes 6/7, are rejected by the ALSU.
    assign req_inv = ((req_red_op_a | req_red_op_b) & (req_opcode[1] | req_opcode[2]))
                   | (req_opcode[2] & req_opcode[1]);

    // Every accepted command holds a credit until its response is popped.
    assign occupancy = count_q + CW'(v0_q) + CW'(v1_q) + CW'(v2_q);
    assign req_ready = occupancy < CW'(DEPTH);
    assign req_fire  = req_valid & req_ready;

    assign rsp_valid   = (count_q != '0);
    assign rd_data     = mem_q[rd_ptr_q];
    assign rsp_out     = rsp_valid ? rd_data[6:1] : 6'h00;
    assign rsp_invalid = rsp_valid & rd_data[0];
    assign proto_err   = err_q;

    always_comb begin
        pins_d   = req_fire ? req_pins : PINS_NOP;

        // Stage 0: pins loaded; stage 1: ALSU input regs; stage 2: alsu_out valid.
        v0_d     = req_fire;
        v1_d     = v0_q;
        v2_d     = v1_q;
        inv0_d   = req_fire & req_inv;
        inv1_d   = inv0_q;
        inv2_d   = inv1_q;

        push     = v2_q;
        pop      = rsp_valid & rsp_ready;
        full     = (count_q == CW'(DEPTH));
        // When full, a simultaneous pop frees the slot the write lands in.
        wr_en    = push & (~full | pop);

        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (wr_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        err_d = err_q;
        if (push) begin
            // An invalid command must yield zero; a valid one must leave LEDs dark.
            if (inv2_q && (alsu_out != 6'h00)) begin
                err_d = 1'b1;
            end
            if (!inv2_q && (alsu_leds != 16'h0000)) begin
                err_d = 1'b1;
            end
            if (full && !pop) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pins_q   <= PINS_NOP;
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            inv0_q   <= 1'b0;
            inv1_q   <= 1'b0;
            inv2_q   <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            pins_q   <= pins_d;
            v0_q     <= v0_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            inv0_q   <= inv0_d;
            inv1_q   <= inv1_d;
            inv2_q   <= inv2_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {alsu_out, inv2_q};
        end
    end

endmodule

// File: tb/tb_alsu_driver.sv
// tb/tb_alsu_driver.sv - self-checking bench for alsu_driver with a behavioural ALSU

module tb_alsu_driver;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0] opcode;
        logic [2:0] a;
        logic [2:0] b;
        logic       cin;
        logic       serial_in;
        logic       direction;
        logic       red_a;
        logic       red_b;
        logic       byp_a;
        logic       byp_b;
    } cmd_t;

    localparam cmd_t NOP_CMD = 16'h0002;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    cmd_t        req_cmd = 16'h0000;
    logic        req_ready;
    logic [2:0]  alsu_opcode, alsu_a, alsu_b;
    logic        alsu_cin, alsu_serial_in, alsu_direction;
    logic        alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
    logic [5:0]  alsu_out;
    logic [15:0] alsu_leds;
    logic        rsp_valid, rsp_invalid, proto_err;
    logic [5:0]  rsp_out;

    int n_checks = 0;
    int n_fail   = 0;
    int n_fired  = 0;

    always #5 clk = ~clk;

    alsu_driver #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_cmd.opcode), .req_a(req_cmd.a), .req_b(req_cmd.b),
        .req_cin(req_cmd.cin), .req_serial_in(req_cmd.serial_in),
        .req_direction(req_cmd.direction),
        .req_red_op_a(req_cmd.red_a), .req_red_op_b(req_cmd.red_b),
        .req_bypass_a(req_cmd.byp_a), .req_bypass_b(req_cmd.byp_b),
        .alsu_opcode(alsu_opcode), .alsu_a(alsu_a), .alsu_b(alsu_b),
        .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in),
        .alsu_direction(alsu_direction),
        .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
        .alsu_out(alsu_out), .alsu_leds(alsu_leds),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_invalid(rsp_invalid), .proto_err(proto_err)
    );

    // ---------------- behavioural ALSU ----------------
    function automatic logic is_invalid(input cmd_t c);
        return (c.opcode inside {3'd6, 3'd7}) ||
               ((c.red_a || c.red_b) && (c.opcode inside {[3'd2:3'd7]}));
    endfunction

    function automatic logic [5:0] alsu_fn(input cmd_t c, input logic [5:0] prev);
        int ia, ib;
        ia = $signed(c.a);
        ib = $signed(c.b);
        if (is_invalid(c)) return 6'h00;
        if (c.byp_a) return 6'(ia);
        if (c.byp_b) return 6'(ib);
        case (c.opcode)
            3'd0: return c.red_a ? {5'b0, &c.a} : c.red_b ? {5'b0, &c.b} : 6'(ia & ib);
            3'd1: return c.red_a ? {5'b0, ^c.a} : c.red_b ? {5'b0, ^c.b} : 6'(ia ^ ib);
            3'd2: return 6'(ia + ib + int'(c.cin));
            3'd3: return 6'(ia * ib);
            3'd4: return c.direction ? {prev[4:0], c.serial_in} : {c.serial_in, prev[5:1]};
            default: return c.direction ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
        endcase
    endfunction

    cmd_t        pin_cmd;
    cmd_t        dev_in_q;
    logic [5:0]  dev_out_q;
    logic [15:0] dev_leds_q;
    logic        force_en = 1'b0;

    assign pin_cmd = {alsu_opcode, alsu_a, alsu_b, alsu_cin, alsu_serial_in,
                      alsu_direction, alsu_red_op_A, alsu_red_op_B,
                      alsu_bypass_A, alsu_bypass_B};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dev_in_q   <= NOP_CMD;
            dev_out_q  <= 6'h00;
            dev_leds_q <= 16'h0000;
        end else begin
            dev_in_q   <= pin_cmd;
            dev_out_q  <= alsu_fn(dev_in_q, dev_out_q);
            dev_leds_q <= is_invalid(dev_in_q) ? 16'hFFFF : 16'h0000;
        end
    end

    assign alsu_out  = force_en ? 6'h01 : dev_out_q;
    assign alsu_leds = dev_leds_q;

    // ---------------- transaction-level reference ----------------
    // A command chains on the result of the command accepted the cycle before,
    // or on zero when that cycle was idle (the NOP result).
    logic [6:0] exp_q[$];
    logic [6:0] obs_q[$];
    logic       fired_prev = 1'b0;
    logic [5:0] prev_res = 6'h00;
    logic       last_fire = 1'b0;

    task automatic cycle();
        logic       f, p;
        logic [5:0] r;
        f = req_valid && req_ready;
        p = rsp_valid && rsp_ready;
        if (p) obs_q.push_back({rsp_out, rsp_invalid});
        if (f) begin
            r = alsu_fn(req_cmd, fired_prev ? prev_res : 6'h00);
            exp_q.push_back({r, is_invalid(req_cmd)});
            prev_res = r;
            n_fired++;
        end
        fired_prev = f;
        last_fire  = f;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic drain(input int n);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        rsp_ready = 1'b0;
    endtask

    function automatic cmd_t mk(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
        cmd_t c;
        c = 16'h0000;
        c.opcode = op;
        c.a = a;
        c.b = b;
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c = cmd_t'(16'($urandom()));
        if ($urandom_range(3) != 0) begin
            c.byp_a = 1'b0;
            c.byp_b = 1'b0;
        end
        if ($urandom_range(2) != 0) begin
            c.red_a = 1'b0;
            c.red_b = 1'b0;
        end
        return c;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++;
        if (rsp_out !== 6'h00) begin n_fail++; $display("FAIL reset_rsp_out: got %h want 00", rsp_out); end
        n_checks++;
        if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
        n_checks++;
        if (pin_cmd !== NOP_CMD) begin n_fail++; $display("FAIL reset_pins_nop: got %h want %h", pin_cmd, NOP_CMD); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        fired_prev = 1'b0;
        clear_sb();
    endtask

    task automatic test_directed();
        int lat;
        clear_sb();
        rsp_ready = 1'b0;
        req_cmd = mk(3'd2, 3'd3, 3'd2);
        req_cmd.cin = 1'b1;
        req_valid = 1'b1;
        cycle();
        req_valid = 1'b0;
        n_checks++;
        if (pin_cmd !== req_cmd) begin n_fail++; $display("FAIL pins_loaded: got %h want %h", pin_cmd, req_cmd); end
        cycle();
        n_checks++;
        if (pin_cmd !== NOP_CMD) begin n_fail++; $display("FAIL pins_idle_nop: got %h want %h", pin_cmd, NOP_CMD); end
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            cycle();
            lat++;
        end
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d want 3", lat); end
        n_checks++;
        if (rsp_out !== 6'h06 || rsp_invalid !== 1'b0)
            begin n_fail++; $display("FAIL add_result: got %h/%b want 06/0", rsp_out, rsp_invalid); end
        drain(3);

        clear_sb();
        req_valid = 1'b1;
        req_cmd = mk(3'd3, 3'b110, 3'd3);
        cycle();
        req_cmd = mk(3'd6, 3'd1, 3'd1);
        cycle();
        drain(8);
        n_checks++;
        if (obs_q.size() !== 2) begin
            n_fail++; $display("FAIL mult_inv_count: got %0d want 2", obs_q.size());
        end else begin
            n_checks++;
            if (obs_q[0] !== {6'h3A, 1'b0}) begin n_fail++; $display("FAIL mult_result: got %h want %h", obs_q[0], {6'h3A, 1'b0}); end
            n_checks++;
            if (obs_q[1] !== {6'h00, 1'b1}) begin n_fail++; $display("FAIL invalid_result: got %h want %h", obs_q[1], {6'h00, 1'b1}); end
        end
        n_checks++;
        if (proto_err !== 1'b0) begin n_fail++; $display("FAIL invalid_no_err: got %b want 0", proto_err); end
    endtask

    task automatic test_back_to_back();
        clear_sb();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_cmd = mk(3'd0, 3'b101, 3'd0);
        req_cmd.byp_a = 1'b1;
        cycle();
        req_cmd = mk(3'd4, 3'd0, 3'd0);
        req_cmd.direction = 1'b1;
        req_cmd.serial_in = 1'b0;
        cycle();
        drain(8);
        n_checks++;
        if (obs_q.size() !== 2) begin
            n_fail++; $display("FAIL chain_count: got %0d want 2", obs_q.size());
        end else begin
            n_checks++;
            if (obs_q[0][6:1] !== 6'h3D) begin n_fail++; $display("FAIL chain_bypass: got %h want 3d", obs_q[0][6:1]); end
            n_checks++;
            if (obs_q[1][6:1] !== 6'h3A) begin n_fail++; $display("FAIL chain_shift: got %h want 3a", obs_q[1][6:1]); end
        end
    endtask

    task automatic test_backpressure();
        cmd_t cmds[6];
        int   idx, guard;
        clear_sb();
        for (int i = 0; i < 6; i++) cmds[i] = rand_cmd();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            req_cmd = cmds[idx];
            cycle();
            if (last_fire) idx++;
        end
        n_checks++;
        if (idx !== DEPTH) begin n_fail++; $display("FAIL bp_accepted: got %0d want %0d", idx, DEPTH); end
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", req_ready); end
        rsp_ready = 1'b1;
        guard = 0;
        while (idx < 6 && guard < 50) begin
            req_cmd = cmds[idx];
            cycle();
            if (last_fire) idx++;
            guard++;
        end
        n_checks++;
        if (idx !== 6) begin n_fail++; $display("FAIL bp_remaining: got %0d want 6", idx); end
        drain(10);
        n_checks++;
        if (obs_q.size() !== exp_q.size() || exp_q.size() !== 6) begin
            n_fail++; $display("FAIL bp_count: got %0d want 6", obs_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_random();
        clear_sb();
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(9) < 7);
            rsp_ready = ($urandom_range(9) < 6);
            req_cmd   = rand_cmd();
            cycle();
        end
        drain(12);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_rsp[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
            end
        end
        n_checks++;
        if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rand_no_err: got %b want 0", proto_err); end
    endtask

    task automatic test_reset_mid();
        clear_sb();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_cmd = mk(3'd2, 3'(i + 1), 3'd1);
            cycle();
        end
        req_valid = 1'b0;
        cycle();
        n_checks++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_queued: got %b want 1", rsp_valid); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_out !== 6'h00)
            begin n_fail++; $display("FAIL mid_reset_rsp: got %b/%h want 0/00", rsp_valid, rsp_out); end
        n_checks++;
        if (pin_cmd !== NOP_CMD) begin n_fail++; $display("FAIL mid_reset_pins: got %h want %h", pin_cmd, NOP_CMD); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        fired_prev = 1'b0;
        clear_sb();
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", req_ready); end
        drain(10);
        n_checks++;
        if (obs_q.size() !== 0) begin n_fail++; $display("FAIL mid_stale: got %0d responses want 0", obs_q.size()); end
    endtask

    task automatic test_proto_err();
        clear_sb();
        force_en = 1'b1;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_cmd = mk(3'd6, 3'd2, 3'd2);
        cycle();
        req_valid = 1'b0;
        repeat (5) cycle();
        n_checks++;
        if (proto_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", proto_err); end
        force_en = 1'b0;
        drain(8);
        n_checks++;
        if (proto_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", proto_err); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (proto_err !== 1'b0) begin n_fail++; $display("FAIL err_reset: got %b want 0", proto_err); end
        rst = 1'b1;
        fired_prev = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_proto_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
